// File: rtl/keypad_pkg.sv
// Shared keypad types and helpers: FSM state encoding, default geometry and
// debounce depth, and the linear key-code function used by the scanner.
// Combinational content only; no latency and no flow control.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        DEB  = 2'd1,
        HELD = 2'd2
    } kp_state_t;

    localparam int KP_ROWS           = 5;
    localparam int KP_COLS           = 4;
    localparam int KP_DEBOUNCE_TICKS = 8;

    // Linear key address: row-major over the keypad matrix.
    function automatic int key_code_f(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Prescaler: one-cycle tick every DIV clk cycles, restartable via clr.
// Latency: first tick DIV cycles after rst/clr is released.
// Backpressure: none; free-running.
//
// Ports: clk, rst (sync, active-high), clr (sync restart), tick (1-cycle strobe).
module keypad_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] divCnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            divCnt <= '0;
        end else if (divCnt == LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CW'(1);
        end
    end

    assign tick = (divCnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner: drives one column at a time, debounces a single-row press,
// emits a linear key code with a one-cycle valid pulse per accepted press.
// Latency: accept DEBOUNCE_TICKS scan ticks after first sample; no backpressure.
//
// Ports: clk, rst (sync, active-high), row_in[ROWS] row sense,
//        col_n[COLS] one-hot active-low column drive, key_code[CODE_W],
//        key_valid (1-cycle pulse), key_held (accepted key still down).
// Build option: KEYPAD_REPEAT_EN adds auto-repeat pulses every
//        4*DEBOUNCE_TICKS ticks while the accepted key stays down.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS           = KP_ROWS,
    parameter  int COLS           = KP_COLS,
    parameter  int SCAN_DIV       = 50000,
    parameter  int DEBOUNCE_TICKS = KP_DEBOUNCE_TICKS,
    localparam int CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

    logic tick;

    keypad_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (tick)
    );

    kp_state_t         state,   stateNext;
    logic [COL_W-1:0]  colIdx,  colNext;
    logic [ROW_W-1:0]  rowIdx,  rowNext;
    logic [CNT_W-1:0]  cnt,     cntNext;
    logic [CNT_W-1:0]  rel,     relNext;
    logic [CODE_W-1:0] keyCode, codeNext;
    logic              keyValid, validNext;
    logic              keyHeld,  heldNext;
`ifdef KEYPAD_REPEAT_EN
    localparam int               RPT_W    = $clog2(4 * DEBOUNCE_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_DONE = RPT_W'(4 * DEBOUNCE_TICKS);
    logic [RPT_W-1:0]  rpt, rptNext;
`endif

    // Row decode: a press is only meaningful when exactly one row is high;
    // two or more high rows in one column indicate ghosting.
    logic             rowSingle;
    logic [ROW_W-1:0] rowHit;
    logic [COL_W-1:0] colAdv;
    logic             doAccept;

    always_comb begin
        rowHit = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_in[i]) rowHit = ROW_W'(i);
        end
        rowSingle = (row_in != '0) && ((row_in & (row_in - ROWS'(1))) == '0);
        colAdv    = (colIdx == COL_W'(COLS - 1)) ? '0 : colIdx + COL_W'(1);
    end

    always_comb begin
        stateNext = state;
        colNext   = colIdx;
        rowNext   = rowIdx;
        cntNext   = cnt;
        relNext   = rel;
        codeNext  = keyCode;
        validNext = 1'b0;
        heldNext  = keyHeld;
        doAccept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rptNext   = rpt;
`endif
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (rowSingle) begin
                        rowNext   = rowHit;
                        cntNext   = CNT_W'(1);
                        stateNext = DEB;
                        doAccept  = (DEBOUNCE_TICKS == 1);
                    end else begin
                        colNext = colAdv;
                    end
                end
                DEB: begin
                    if (rowSingle && (rowHit == rowIdx)) begin
                        cntNext  = cnt + CNT_W'(1);
                        doAccept = ((cnt + CNT_W'(1)) == CNT_DONE);
                    end else begin
                        cntNext   = '0;
                        colNext   = colAdv;
                        stateNext = SCAN;
                    end
                end
                HELD: begin
                    // Only the accepted row matters; other rows are ignored.
                    if (!row_in[rowIdx]) begin
                        relNext = rel + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                        rptNext = '0;
`endif
                        if ((rel + CNT_W'(1)) == CNT_DONE) begin
                            relNext   = '0;
                            heldNext  = 1'b0;
                            colNext   = colAdv;
                            stateNext = SCAN;
                        end
                    end else begin
                        relNext = '0;
`ifdef KEYPAD_REPEAT_EN
                        rptNext = rpt + RPT_W'(1);
                        if ((rpt + RPT_W'(1)) == RPT_DONE) begin
                            rptNext   = '0;
                            validNext = 1'b1;
                        end
`endif
                    end
                end
                default: stateNext = SCAN;
            endcase

            if (doAccept) begin
                codeNext  = CODE_W'(key_code_f(int'(rowNext), int'(colIdx), COLS));
                validNext = 1'b1;
                heldNext  = 1'b1;
                cntNext   = '0;
                relNext   = '0;
                stateNext = HELD;
`ifdef KEYPAD_REPEAT_EN
                rptNext   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            colIdx   <= '0;
            rowIdx   <= '0;
            cnt      <= '0;
            rel      <= '0;
            keyCode  <= '0;
            keyValid <= 1'b0;
            keyHeld  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt      <= '0;
`endif
        end else begin
            state    <= stateNext;
            colIdx   <= colNext;
            rowIdx   <= rowNext;
            cnt      <= cntNext;
            rel      <= relNext;
            keyCode  <= codeNext;
            keyValid <= validNext;
            keyHeld  <= heldNext;
`ifdef KEYPAD_REPEAT_EN
            rpt      <= rptNext;
`endif
        end
    end

    // Masking with rst keeps a pulse already registered from leaking out
    // during the reset cycle.
    assign key_valid = keyValid & ~rst;
    assign key_code  = keyCode;
    assign key_held  = keyHeld;
    assign col_n     = ~(COLS'(1) << colIdx);

endmodule
